// File: rtl/spriter_pkg.sv
// Shared constants and types for the spriter command path: field widths,
// screen geometry, anchor limit, command record and queue FSM encoding.
package spriter_pkg;

  localparam int ANC_W    = 19;
  localparam int SPN_W    = 5;
  localparam int CMD_W    = SPN_W + ANC_W;
  localparam int CNT_W    = 6;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int ANC_MAX  = H_ACTIVE * V_ACTIVE;

  // One queued anchor-update command.
  typedef struct packed {
    logic [SPN_W-1:0] sp_num;
    logic [ANC_W-1:0] ancora;
  } sprite_cmd_t;

  // Issue FSM encoding; exposed on the top-level state_dbg port.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

endpackage

// File: rtl/sprite_cmd_fifo.sv
// Circular command buffer: DEPTH entries, wrapping pointers, separate occupancy
// counter. Push/pop arrive pre-qualified from the owner; clr empties the buffer.
module sprite_cmd_fifo
  import spriter_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  sprite_cmd_t      din,
  output sprite_cmd_t      dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  sprite_cmd_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage write; contents need no reset because count guards every read.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/sprite_cmd_queue.sv
// Buffers sprite anchor updates from the processor side and issues them one at
// a time to the spriter, optionally only during vertical blanking.
// Handshake: a request is offered while change_rq=1 with sp_num/ancora_in held
// stable; it is accepted in any cycle where change_rq=1 and ready=1. Once up,
// the request is never withdrawn except by reset or flush. After each accept
// change_rq stays low for one cycle so the spriter can drop ready.
module sprite_cmd_queue #(
  parameter int DEPTH    = 8,
  parameter int V_ACTIVE = spriter_pkg::V_ACTIVE,
  parameter int VBL_ONLY = 1,
  parameter int ANC_MAX  = spriter_pkg::ANC_MAX
) (
  input  logic        clk_75,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  wr_sp_num,
  input  logic [18:0] wr_ancora,
  input  logic        flush,
  input  logic [9:0]  row,
  input  logic        ready,
  output logic        change_rq,
  output logic [4:0]  sp_num,
  output logic [18:0] ancora_in,
  output logic        full,
  output logic        empty,
  output logic [5:0]  count,
  output logic        overflow,
  output logic        range_err,
  output logic [1:0]  state_dbg
);

  import spriter_pkg::*;

  logic        [1:0] state;
  sprite_cmd_t       head;
  sprite_cmd_t       wr_cmd;
  logic              win;
  logic              accept;
  logic              bad_anc;
  logic              push_ok;
  logic              push_full;

  assign win       = (VBL_ONLY != 0) ? (int'(row) >= V_ACTIVE) : 1'b1;
  assign accept    = (state == ST_ISSUE) && ready;
  assign bad_anc   = int'(wr_ancora) >= ANC_MAX;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign push_ok   = wr_en && !bad_anc && (!full || accept) && !flush;
  assign push_full = wr_en && !bad_anc && full && !accept;
  assign wr_cmd    = '{sp_num: wr_sp_num, ancora: wr_ancora};

  sprite_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk_75),
    .rst   (reset),
    .clr   (flush),
    .push  (push_ok),
    .pop   (accept),
    .din   (wr_cmd),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Issue FSM; request data is captured from the head on entry to ISSUE.
  always_ff @(posedge clk_75 or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      sp_num    <= '0;
      ancora_in <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      sp_num    <= '0;
      ancora_in <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_GAP: begin
          if (!empty) begin
            if (win) begin
              state     <= ST_ISSUE;
              sp_num    <= head.sp_num;
              ancora_in <= head.ancora;
            end else begin
              state <= ST_WAIT;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (win) begin
            state     <= ST_ISSUE;
            sp_num    <= head.sp_num;
            ancora_in <= head.ancora;
          end
        end
        ST_ISSUE: begin
          if (ready) state <= ST_GAP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flags; a bad anchor is reported as range_err only.
  always_ff @(posedge clk_75 or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      range_err <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      range_err <= 1'b0;
    end else begin
      if (push_full)        overflow  <= 1'b1;
      if (wr_en && bad_anc) range_err <= 1'b1;
    end
  end

  assign change_rq = (state == ST_ISSUE);
  assign state_dbg = state;

endmodule

// File: tb/tb_sprite_cmd_queue.sv
// Directed bench for sprite_cmd_queue with hand-computed expectations.
module tb_sprite_cmd_queue;

  logic        clk_75;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_sp_num;
  logic [18:0] wr_ancora;
  logic        flush;
  logic [9:0]  row;
  logic        ready;
  logic        change_rq;
  logic [4:0]  sp_num;
  logic [18:0] ancora_in;
  logic        full;
  logic        empty;
  logic [5:0]  count;
  logic        overflow;
  logic        range_err;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] exp_q[$];

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  sprite_cmd_queue #(.DEPTH(8), .V_ACTIVE(480), .VBL_ONLY(1), .ANC_MAX(307200)) dut (
    .clk_75    (clk_75),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_sp_num (wr_sp_num),
    .wr_ancora (wr_ancora),
    .flush     (flush),
    .row       (row),
    .ready     (ready),
    .change_rq (change_rq),
    .sp_num    (sp_num),
    .ancora_in (ancora_in),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .range_err (range_err),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk_75 = 1'b0;
  always #5 clk_75 = ~clk_75;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 ns after the edge.
  task automatic tick();
    @(posedge clk_75);
    #1;
  endtask

  task automatic push(input logic [4:0] sp, input logic [18:0] anc);
    wr_en     = 1'b1;
    wr_sp_num = sp;
    wr_ancora = anc;
    tick();
    wr_en     = 1'b0;
  endtask

  task automatic wait_rq(input string tag, input int limit, output int waited);
    waited = 0;
    while (!change_rq && waited < limit) begin
      tick();
      waited++;
    end
    check({tag, "_rq_timeout"}, change_rq, 1);
  endtask

  // Drain n entries with ready high, checking order and 2-cycle spacing.
  task automatic drain(input string tag, input int n);
    int w;
    logic [23:0] e;
    for (int k = 0; k < n; k++) begin
      wait_rq(tag, 4, w);
      check($sformatf("%s_spacing%0d", tag, k), w, 1);
      if (exp_q.size() == 0) begin
        check($sformatf("%s_extra%0d", tag, k), 1, 0);
        e = '0;
      end else begin
        e = exp_q.pop_front();
      end
      check($sformatf("%s_sp%0d", tag, k), sp_num, e[23:19]);
      check($sformatf("%s_anc%0d", tag, k), ancora_in, e[18:0]);
      tick();
      check($sformatf("%s_gap%0d", tag, k), change_rq, 0);
    end
  endtask

  initial begin
    int w;
    logic [4:0]  held_sp;
    logic [18:0] held_anc;
    reset = 1'b1; wr_en = 1'b0; wr_sp_num = '0; wr_ancora = '0;
    flush = 1'b0; row = '0; ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_rq", change_rq, 0);
    check("rst_sp", sp_num, 0);
    check("rst_anc", ancora_in, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_rerr", range_err, 0);
    check("rst_state", state_dbg, S_IDLE);
    reset = 1'b0;
    tick();

    // 1: command waits for the blanking window
    row = 10'd100;
    push(5'd3, 19'd1000);
    tick(); tick();
    check("t1_hold_rq", change_rq, 0);
    check("t1_wait_state", state_dbg, S_WAIT);
    check("t1_count", count, 1);
    row = 10'd480;
    tick();
    check("t1_rq", change_rq, 1);
    check("t1_sp", sp_num, 3);
    check("t1_anc", ancora_in, 1000);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t1_rq_drop", change_rq, 0);
    check("t1_empty", empty, 1);
    tick();
    check("t1_idle", state_dbg, S_IDLE);

    // 2: fill, overflow, ordered drain
    row = 10'd100;
    for (int i = 1; i <= 8; i++) begin
      push(5'(i), 19'(100 * i));
      exp_q.push_back({5'(i), 19'(100 * i)});
    end
    check("t2_full_pre", full, 1);
    check("t2_ovf_pre", overflow, 0);
    push(5'd9, 19'd900);
    check("t2_full", full, 1);
    check("t2_ovf", overflow, 1);
    check("t2_count", count, 8);
    row = 10'd480;
    ready = 1'b1;
    drain("t2", 8);
    ready = 1'b0;
    check("t2_empty", empty, 1);
    check("t2_ovf_sticky", overflow, 1);
    tick();

    // 3: anchor range
    row = 10'd100;
    push(5'd2, 19'd307200);
    check("t3_rerr", range_err, 1);
    check("t3_count_bad", count, 0);
    push(5'd4, 19'd307199);
    check("t3_count_ok", count, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_flush_ovf", overflow, 0);
    check("t3_flush_rerr", range_err, 0);
    check("t3_flush_count", count, 0);

    // 4: push and accept in the same cycle while full
    for (int i = 1; i <= 8; i++) begin
      push(5'(10 + i), 19'(2000 + i));
      exp_q.push_back({5'(10 + i), 19'(2000 + i)});
    end
    row = 10'd480;
    tick();
    check("t4_rq", change_rq, 1);
    check("t4_head_sp", sp_num, 11);
    check("t4_head_anc", ancora_in, 2001);
    void'(exp_q.pop_front());
    ready = 1'b1;
    wr_en = 1'b1; wr_sp_num = 5'd20; wr_ancora = 19'd3000;
    exp_q.push_back({5'd20, 19'd3000});
    tick();
    wr_en = 1'b0;
    check("t4_count", count, 8);
    check("t4_ovf", overflow, 0);
    check("t4_gap", change_rq, 0);
    drain("t4", 8);
    ready = 1'b0;
    check("t4_empty", empty, 1);
    check("t4_q_used", exp_q.size(), 0);
    tick();

    // 5: request held through window close while ready is low
    push(5'd7, 19'd4242);
    check("t5_latency1", change_rq, 0);
    push(5'd8, 19'd4343);
    check("t5_latency2", change_rq, 1);
    held_sp  = sp_num;
    held_anc = ancora_in;
    check("t5_sp", held_sp, 7);
    check("t5_anc", held_anc, 4242);
    row = 10'd100;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("t5_hold_rq%0d", i), change_rq, 1);
      check($sformatf("t5_hold_sp%0d", i), sp_num, 7);
      check($sformatf("t5_hold_anc%0d", i), ancora_in, 4242);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t5_rq_drop", change_rq, 0);
    check("t5_single_pop", count, 1);
    tick();
    check("t5_wait", state_dbg, S_WAIT);
    check("t5_wait_rq", change_rq, 0);

    // 6a: asynchronous reset during ISSUE
    row = 10'd480;
    tick();
    check("t6_rq", change_rq, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_rq", change_rq, 0);
    check("t6_async_count", count, 0);
    check("t6_async_state", state_dbg, S_IDLE);
    tick();
    reset = 1'b0;
    tick();

    // 6b: flush during ISSUE with sticky flags set
    row = 10'd100;
    for (int i = 0; i < 9; i++) push(5'(i), 19'(50 + i));
    push(5'd1, 19'd400000);
    check("t6_ovf_set", overflow, 1);
    check("t6_rerr_set", range_err, 1);
    row = 10'd480;
    wait_rq("t6", 4, w);
    flush = 1'b1;
    #1;
    check("t6_flush_pre", change_rq, 1);
    tick();
    flush = 1'b0;
    check("t6_flush_rq", change_rq, 0);
    check("t6_flush_count", count, 0);
    check("t6_flush_empty", empty, 1);
    check("t6_flush_ovf", overflow, 0);
    check("t6_flush_rerr", range_err, 0);
    check("t6_flush_sp", sp_num, 0);
    check("t6_flush_anc", ancora_in, 0);
    check("t6_flush_state", state_dbg, S_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
